// File: rtl/switch_bounce_gen_pkg.sv
// Shared definitions for the switch bounce emulator and its LFSR.
package switch_bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHATTER = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  localparam int unsigned LFSR_W = 16;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/switch_bounce_gen_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, shifting left; reused by other stimulus generators.
module lfsr_16
  import switch_bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_lfsr
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_lfsr <= SEED;
    else       o_lfsr <= {o_lfsr[14:0], ^(o_lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: on a commanded level change, emits pseudo-random
// chatter, forces the final level, then holds it clean for a settle period.
module switch_bounce_gen
  import switch_bounce_gen_pkg::*;
#(
  parameter int unsigned BOUNCE_COUNT  = 8,
  parameter int unsigned MIN_GAP       = 16,
  parameter int unsigned GAP_BITS      = 4,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_bounce_en,
  output logic o_switch,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));
  localparam int unsigned BC_W  = $clog2(BOUNCE_COUNT + 1);
  localparam int unsigned ST_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(MIN_GAP);
  localparam logic [BC_W-1:0]  BC_INIT  = BC_W'(BOUNCE_COUNT);
  localparam logic [ST_W-1:0]  ST_INIT  = ST_W'(SETTLE_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr;
  logic [GAP_W-1:0]  gap_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BC_W-1:0]   bounce_cnt;
  logic [ST_W-1:0]   settle_cnt;
  logic              target;
  logic              unused_lfsr;
  state_t            state;

  lfsr_16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_lfsr (lfsr)
  );

  // Only the low GAP_BITS of the LFSR randomise the gap.
  assign gap_next    = GAP_MIN + GAP_W'(lfsr[GAP_BITS-1:0]);
  assign unused_lfsr = ^lfsr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      o_switch   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      gap_cnt    <= '0;
      bounce_cnt <= '0;
      settle_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_level != target) begin
            target <= i_level;
            if (i_bounce_en) begin
              gap_cnt    <= gap_next;
              bounce_cnt <= BC_INIT;
              o_busy     <= 1'b1;
              state      <= CHATTER;
            end else begin
              o_switch <= i_level;
            end
          end
        end
        CHATTER: begin
          target <= i_level;
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (bounce_cnt != '0) begin
            o_switch   <= ~o_switch;
            bounce_cnt <= bounce_cnt - 1'b1;
            gap_cnt    <= gap_next;
          end else begin
            o_switch   <= target;
            settle_cnt <= ST_INIT;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          o_switch <= target;
          // Completion wins over a same-edge level change; IDLE picks it up next.
          if (settle_cnt == '0) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (i_level != target) begin
            target     <= i_level;
            gap_cnt    <= gap_next;
            bounce_cnt <= BC_INIT;
            state      <= CHATTER;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: stimulus pushes expected o_switch
// transitions and o_done pulses with their edge numbers; a monitor pops and compares.
module tb_switch_bounce_gen;

  localparam int unsigned BC = 4;
  localparam int unsigned MG = 2;
  localparam int unsigned GB = 2;
  localparam int unsigned SC = 10;

  localparam int EV_SW   = 0;
  localparam int EV_DONE = 1;

  typedef struct {
    int   kind;
    logic val;
    int   cyc;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_level = 1'b0;
  logic i_bounce_en = 1'b0;
  logic o_switch;
  logic o_busy;
  logic o_done;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  ev_t  sb[$];
  logic [15:0] m;
  logic prev_sw = 1'b0;

  switch_bounce_gen #(
    .BOUNCE_COUNT  (BC),
    .MIN_GAP       (MG),
    .GAP_BITS      (GB),
    .SETTLE_CYCLES (SC),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_level     (i_level),
    .i_bounce_en (i_bounce_en),
    .o_switch    (o_switch),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: value held here is the one the DUT uses at the next edge.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) m <= 16'hACE1;
    else       m <= lfsr_step(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input logic val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    sb.push_back(e);
  endfunction

  task automatic expect_ev(input int kind, input logic val);
    ev_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d val %0b at edge %0d, expected none", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_val", val, e.val);
      check("ev_edge", cyc, e.cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_sw = 1'b0;
    end else begin
      if (o_switch !== prev_sw) begin
        expect_ev(EV_SW, o_switch);
        prev_sw = o_switch;
      end
      if (o_done === 1'b1) expect_ev(EV_DONE, 1'b1);
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  // Predict a full chatter burst starting at detect edge d with LFSR value l0.
  task automatic plan(input int d, input logic [15:0] l0, input logic sw0, input logic tgt,
                      input bit with_done, output int tf, output int t1, output int t2);
    int t;
    int g;
    logic [15:0] lf;
    logic sw;
    t  = d;
    lf = l0;
    sw = sw0;
    t1 = 0;
    t2 = 0;
    for (int i = 0; i <= int'(BC); i++) begin
      g = int'(MG) + int'(lf[1:0]);
      for (int j = 0; j < g + 1; j++) lf = lfsr_step(lf);
      t = t + g + 1;
      if (i < int'(BC)) begin
        sw = ~sw;
        push(EV_SW, sw, t);
        if (i == 0) t1 = t;
        if (i == 1) t2 = t;
      end else if (tgt != sw) begin
        push(EV_SW, tgt, t);
      end
    end
    tf = t;
    if (with_done) push(EV_DONE, 1'b1, tf + int'(SC));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_until(input int e);
    int n = 0;
    while (cyc < e && n < 500) begin
      step();
      n++;
    end
    check("wait_edge", cyc, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int tf, t1, t2;

    // Reset held with i_level toggling
    for (int i = 0; i < 5; i++) begin
      step();
      i_level = ~i_level;
      check("rst_switch", o_switch, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
    end
    i_level = 1'b0;
    i_rst   = 1'b0;
    check("lfsr_seed", dut.u_lfsr.o_lfsr, 16'hACE1);
    step();
    check("lfsr_first_step", dut.u_lfsr.o_lfsr, 16'h59C3);

    // Bypass: one-edge latency both directions
    i_bounce_en = 1'b0;
    i_level = 1'b1;
    push(EV_SW, 1'b1, cyc + 1);
    step();
    check("bypass_busy", o_busy, 0);
    check("bypass_done", o_done, 0);
    step();
    i_level = 1'b0;
    push(EV_SW, 1'b0, cyc + 1);
    step();
    step();
    drain("bypass");

    // Full bounce 0 -> 1
    i_bounce_en = 1'b1;
    i_level = 1'b1;
    plan(cyc + 1, m, 1'b0, 1'b1, 1'b1, tf, t1, t2);
    step();
    check("bounce_busy_set", o_busy, 1);
    drain("bounce");
    check("bounce_done_pulse", o_done, 1);
    check("bounce_busy_clr", o_busy, 0);
    step();
    check("bounce_done_single", o_done, 0);

    // Level reverts mid-chatter: final level is the latest target
    i_bounce_en = 1'b0;
    i_level = 1'b0;
    push(EV_SW, 1'b0, cyc + 1);
    step();
    step();
    i_bounce_en = 1'b1;
    i_level = 1'b1;
    plan(cyc + 1, m, 1'b0, 1'b0, 1'b1, tf, t1, t2);
    wait_until(t2);
    i_level = 1'b0;
    check("revert_busy", o_busy, 1);
    drain("revert");
    check("revert_done", o_done, 1);
    check("revert_switch", o_switch, 0);

    // Level change at settle cycle 5 restarts the chatter
    step();
    i_level = 1'b1;
    plan(cyc + 1, m, 1'b0, 1'b1, 1'b0, tf, t1, t2);
    wait_until(tf + 4);
    i_level = 1'b0;
    plan(cyc + 1, m, 1'b1, 1'b0, 1'b1, tf, t1, t2);
    drain("resettle");
    check("resettle_done", o_done, 1);
    check("resettle_busy", o_busy, 0);

    // Asynchronous reset mid-chatter
    step();
    i_level = 1'b1;
    plan(cyc + 1, m, 1'b0, 1'b1, 1'b1, tf, t1, t2);
    wait_until(t1);
    check("pre_rst_switch", o_switch, 1);
    i_rst = 1'b1;
    #1;
    check("async_rst_switch", o_switch, 0);
    check("async_rst_busy", o_busy, 0);
    sb.delete();
    i_level = 1'b0;
    step();
    step();
    i_rst = 1'b0;
    step();
    i_level = 1'b1;
    plan(cyc + 1, m, 1'b0, 1'b1, 1'b1, tf, t1, t2);
    step();
    check("post_rst_busy", o_busy, 1);
    drain("post_rst");
    check("post_rst_done", o_done, 1);

    repeat (30) step();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
Synthesizable mechanical-switch emulator that drives a switch line the way a real contact does. When the clean commanded level changes, it produces a burst of pseudo-random chatter, then settles at the new level. It is used on-board and in benches to stimulate debounce logic, with o_switch feeding any i_switch-style input. It also serves as a loopback source in the test top level.

Parameters:
BOUNCE_COUNT, 8, number of chatter toggles before the forced final level (must be ≥2 and even)
MIN_GAP, 16, minimum clock cycles between chatter toggles
GAP_BITS, 4, number of LFSR bits added to MIN_GAP, giving gap G = MIN_GAP + lfsr[GAP_BITS-1:0]
SETTLE_CYCLES, 1000, clean-hold cycles after the final level before o_done
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
i_clk  in  1  system clock, the only clock
i_rst  in  1  asynchronous, active-high reset
i_level  in  1  clean commanded switch level; synchronous to i_clk
i_bounce_en  in  1  1 = emulate bounce, 0 = bypass; sampled only in IDLE
o_switch  out  1  emulated (bouncy) switch line, registered
o_busy  out  1  high while in CHATTER or SETTLE
o_done  out  1  one-cycle pulse at the end of SETTLE

Behaviour:
- Reset values: o_switch=0, o_busy=0, o_done=0, target=0, state=IDLE, lfsr=LFSR_SEED, all counters 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately; there is no o_done.
- The 16-bit Fibonacci LFSR uses x^16+x^14+x^13+x^11+1, shifts left, and advances every clock edge out of reset.
- IDLE:
  - If i_level != target and i_bounce_en=0: target<=i_level and o_switch<=i_level on the same edge (1-cycle latency). State stays IDLE, no o_busy, no o_done.
  - If i_level != target and i_bounce_en=1 (the detect edge): target<=i_level, gap_cnt<=G, bounce_cnt<=BOUNCE_COUNT, state<=CHATTER, o_busy<=1.
- CHATTER:
  - Each edge with gap_cnt!=0: gap_cnt decrements.
  - Each edge with gap_cnt==0 and bounce_cnt!=0: o_switch toggles, bounce_cnt decrements, gap_cnt<=G from the current LFSR value.
  - Edge with gap_cnt==0 and bounce_cnt==0: o_switch<=target, settle_cnt<=SETTLE_CYCLES-1, state<=SETTLE.
  - Spacing between consecutive o_switch transitions is G+1 cycles, bounded to [MIN_GAP+1, MIN_GAP+2^GAP_BITS].
  - The first toggle registers G+1 edges after the detect edge.
  - Because BOUNCE_COUNT is even, the chatter returns to the old level, and the final forced edge is the real transition. Total o_switch transitions = BOUNCE_COUNT+1.
  - i_level changing during CHATTER updates target immediately. The chatter is not restarted, and the final forced level uses the latest target.
- SETTLE:
  - o_switch holds target. settle_cnt decrements each edge.
  - At settle_cnt==0: o_done<=1 for one cycle, o_busy<=0, state<=IDLE.
  - If i_level != target during SETTLE, re-enter CHATTER exactly as a detect edge: reload target, counters, G. No o_done is issued.
- Width rules:
  - gap_cnt width = $clog2(MIN_GAP+2^GAP_BITS).
  - bounce_cnt width = $clog2(BOUNCE_COUNT+1).
  - settle_cnt width = $clog2(SETTLE_CYCLES+1).
  - G is computed at full gap_cnt width with no overflow.
- o_done and an i_level change on the same edge: o_done still pulses. The change is detected in IDLE on the next edge.

Decomposition:
- Shared package holds: state encoding (IDLE=2'd0, CHATTER=2'd1, SETTLE=2'd2), LFSR width (16), and the tap mask constant.
- Sub-module lfsr_16 is free-running, with parameter SEED and ports i_clk, i_rst, o_lfsr[15:0]. It is reused by other stimulus generators.

Test Plan:
All scenarios use BOUNCE_COUNT=4, MIN_GAP=2, GAP_BITS=2, SETTLE_CYCLES=10.
- Reset held 5 cycles with i_level toggling -> o_switch=0, o_busy=0, o_done=0 throughout. The LFSR equals 16'hACE1 at the first edge after release.
- i_bounce_en=0, i_level 0->1 -> o_switch=1 one edge later; o_busy and o_done stay 0.
- i_bounce_en=1, i_level 0->1 -> o_busy=1 next edge, exactly 5 o_switch transitions, each spacing in [3,6] cycles and matching the bench LFSR model, final level 1 -> 10 cycles later a single o_done pulse and o_busy=0.
- During CHATTER, i_level returns 1->0 after the 2nd toggle -> chatter completes 4 toggles, final o_switch=0, o_done pulses once.
- During SETTLE, cycle 5, i_level changes -> CHATTER restarts with 4 new toggles. No o_done until the second settle completes.
- i_rst asserted mid-CHATTER -> o_switch=0 and o_busy=0 asynchronously, before the next clock edge. After release, the IDLE detect works normally.
